sr_reg_bank: RTL and testbench

SR_REG_BANK -- requirements
Module: sr_reg_bank

---
 rtl/sr_reg_bank.sv | 88 ++++++++
 tb/tb_sr_reg_bank.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sr_reg_bank.sv
// rtl/sr_reg_bank.sv - bank of WIDTH independent SR flops with selectable s=r=1 resolution
// Tracks per-channel change pulses and a saturating count of conflicting (s=r=1) cycles.
module sr_reg_bank #(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      CNT_W = 8,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             en,
    input  logic             mode_wr,
    input  logic [1:0]       mode_in,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] changed,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic [1:0]       mode
);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_SET    = 2'b10;
    localparam logic [1:0] MODE_RESET  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_next;
    logic             conflict_hit;

    // Resolution uses the registered mode, so a same-edge mode write affects only later edges.
    always_comb begin
        q_next = q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            case ({s[i], r[i]})
                2'b01:   q_next[i] = 1'b0;
                2'b10:   q_next[i] = 1'b1;
                2'b11: begin
                    case (mode)
                        MODE_HOLD:   q_next[i] = q[i];
                        MODE_TOGGLE: q_next[i] = ~q[i];
                        MODE_SET:    q_next[i] = 1'b1;
                        MODE_RESET:  q_next[i] = 1'b0;
                        default:     q_next[i] = q[i];
                    endcase
                end
                default: q_next[i] = q[i];
            endcase
        end
    end

    assign conflict_hit = en && (|(s & r));

    always_ff @(posedge clk) begin
        if (rst) begin
            q            <= INIT;
            qbar         <= ~INIT;
            changed      <= '0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
            mode         <= MODE_HOLD;
        end else begin
            if (en) begin
                q       <= q_next;
                qbar    <= ~q_next;
                changed <= q_next ^ q;
            end else begin
                changed <= '0;
            end

            conflict <= conflict_hit;

            if (cnt_clr) begin
                conflict_cnt <= '0;
            end else if (conflict_hit && (conflict_cnt != CNT_MAX)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end

            if (mode_wr) begin
                mode <= mode_in;
            end
        end
    end

endmodule

// File: tb/tb_sr_reg_bank.sv
// tb/tb_sr_reg_bank.sv - directed-vector bench for sr_reg_bank
// Each vector compares the packed tuple {q, qbar, changed, conflict, conflict_cnt, mode}.
module tb_sr_reg_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s;
    logic [7:0] r;
    logic       en;
    logic       mode_wr;
    logic [1:0] mode_in;
    logic       cnt_clr;
    logic [7:0] q;
    logic [7:0] qbar;
    logic [7:0] changed;
    logic       conflict;
    logic [1:0] conflict_cnt;
    logic [1:0] mode;

    logic [28:0] obs;
    logic [28:0] exp_v;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    assign obs = {q, qbar, changed, conflict, conflict_cnt, mode};

    always #5 clk = ~clk;

    sr_reg_bank #(
        .WIDTH(8),
        .CNT_W(2),
        .INIT (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s           (s),
        .r           (r),
        .en          (en),
        .mode_wr     (mode_wr),
        .mode_in     (mode_in),
        .cnt_clr     (cnt_clr),
        .q           (q),
        .qbar        (qbar),
        .changed     (changed),
        .conflict    (conflict),
        .conflict_cnt(conflict_cnt),
        .mode        (mode)
    );

    task automatic drive(input logic rst_v, input logic en_v, input logic [7:0] s_v, input logic [7:0] r_v,
                         input logic mwr_v, input logic [1:0] min_v, input logic clr_v);
        rst = rst_v; en = en_v; s = s_v; r = r_v; mode_wr = mwr_v; mode_in = min_v; cnt_clr = clr_v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 2'b11, 1'b0);
        exp_v = {8'h00, 8'hFF, 8'h00, 1'b0, 2'd0, 2'b00};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL reset got %h want %h", obs, exp_v); end
    endtask

    task automatic test_basic();
        drive(1'b0, 1'b1, 8'h0F, 8'hF0, 1'b0, 2'b00, 1'b0);
        exp_v = {8'h0F, 8'hF0, 8'h0F, 1'b0, 2'd0, 2'b00};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL basic_set_reset got %h want %h", obs, exp_v); end
    endtask

    task automatic test_toggle();
        drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 2'b01, 1'b1);
        exp_v = {8'h0F, 8'hF0, 8'h00, 1'b0, 2'd0, 2'b01};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL toggle_mode_load got %h want %h", obs, exp_v); end
        drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 2'b00, 1'b0);
        exp_v = {8'hF0, 8'h0F, 8'hFF, 1'b1, 2'd1, 2'b01};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL toggle_1 got %h want %h", obs, exp_v); end
        drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 2'b00, 1'b0);
        exp_v = {8'h0F, 8'hF0, 8'hFF, 1'b1, 2'd2, 2'b01};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL toggle_2 got %h want %h", obs, exp_v); end
        drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0);
        exp_v = {8'h0F, 8'hF0, 8'h00, 1'b0, 2'd2, 2'b01};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL toggle_idle got %h want %h", obs, exp_v); end
    endtask

    task automatic test_old_mode();
        drive(1'b0, 1'b1, 8'h01, 8'hFE, 1'b1, 2'b11, 1'b0);
        exp_v = {8'h01, 8'hFE, 8'h0E, 1'b0, 2'd2, 2'b11};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL old_mode_setup got %h want %h", obs, exp_v); end
        // Mode 11 (reset-dominant) still applies on the edge that loads mode 10.
        drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b1, 2'b10, 1'b0);
        exp_v = {8'h00, 8'hFF, 8'h01, 1'b1, 2'd3, 2'b10};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL old_mode_reset_dom got %h want %h", obs, exp_v); end
        drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b1, 2'b00, 1'b0);
        exp_v = {8'h01, 8'hFE, 8'h01, 1'b1, 2'd3, 2'b00};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL old_mode_set_dom got %h want %h", obs, exp_v); end
        drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 2'b11, 1'b0);
        exp_v = {8'h01, 8'hFE, 8'h00, 1'b1, 2'd3, 2'b00};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL hold_mode got %h want %h", obs, exp_v); end
    endtask

    task automatic test_saturation();
        logic [1:0] cnt_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1);
        exp_v = {8'h01, 8'hFE, 8'h00, 1'b0, 2'd0, 2'b00};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL sat_clear got %h want %h", obs, exp_v); end
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 2'b00, 1'b0);
            exp_v = {8'h01, 8'hFE, 8'h00, 1'b1, cnt_seq[k], 2'b00};
            vec_cnt++;
            if (obs !== exp_v) begin err_cnt++; $display("FAIL sat_edge%0d got %h want %h", k, obs, exp_v); end
        end
        drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 2'b00, 1'b1);
        exp_v = {8'h01, 8'hFE, 8'h00, 1'b1, 2'd0, 2'b00};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL clr_priority got %h want %h", obs, exp_v); end
    endtask

    task automatic test_enable_and_midreset();
        drive(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 2'b00, 1'b0);
        exp_v = {8'h01, 8'hFE, 8'h00, 1'b0, 2'd0, 2'b00};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL en0_hold got %h want %h", obs, exp_v); end
        drive(1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 2'b00, 1'b0);
        exp_v = {8'h01, 8'hFE, 8'h00, 1'b0, 2'd0, 2'b00};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL en0_no_conflict got %h want %h", obs, exp_v); end
        drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 2'b00, 1'b0);
        exp_v = {8'h01, 8'hFE, 8'h00, 1'b1, 2'd1, 2'b00};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL pre_reset_conflict got %h want %h", obs, exp_v); end
        drive(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 2'b11, 1'b0);
        exp_v = {8'h00, 8'hFF, 8'h00, 1'b0, 2'd0, 2'b00};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL midop_reset got %h want %h", obs, exp_v); end
        drive(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 2'b00, 1'b0);
        exp_v = {8'hFF, 8'h00, 8'hFF, 1'b0, 2'd0, 2'b00};
        vec_cnt++;
        if (obs !== exp_v) begin err_cnt++; $display("FAIL post_reset_set got %h want %h", obs, exp_v); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; s = '0; r = '0; mode_wr = 1'b0; mode_in = 2'b00; cnt_clr = 1'b0;
        test_reset();
        test_basic();
        test_toggle();
        test_old_mode();
        test_saturation();
        test_enable_and_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
